// File: rtl/ahb_fifo_write_pkg.sv
// Shared types for the JTAG-side writer into the AHB async FIFO.
// Holds the holding-register FSM encoding and the bit-counter sizing helper.
// Imported by the writer top and its deserialiser.
package ahb_fifo_write_pkg;

  // Holding-register state: empty, or carrying a word waiting for the FIFO
  typedef enum logic {
    FW_IDLE = 1'b0,
    FW_PUSH = 1'b1
  } fifo_wr_state_t;

  // Bit-counter width for a given word width; never narrower than one bit
  function automatic int fw_cnt_width(input int data_width);
    return (data_width <= 2) ? 1 : $clog2(data_width);
  endfunction

endpackage

// File: rtl/ahb_fifo_write_sipo.sv
// Serial-in parallel-out deserialiser for TDI, LSB first.
// Latency: the completed word is available combinationally with the last bit.
// Backpressure: none; it only advances when shift enable is high and holds otherwise.
module ahb_fifo_write_sipo
  import ahb_fifo_write_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  TCK,
  input  logic                  TRST,
  input  logic                  i_clr,
  input  logic                  i_shift_en,
  input  logic                  i_tdi,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic                  o_done
);

  localparam int CW = fw_cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  // Bit 0 of the architectural shift register is always shifted out before
  // it could reach a completed word, so only the upper DATA_WIDTH-1 bits
  // are kept.
  logic [DATA_WIDTH-2:0] r_shift;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] w_next;
  logic                  w_last;

  // Word as it would look after shifting in the current TDI bit
  always_comb begin
    w_next = {i_tdi, r_shift};
    w_last = (r_cnt == LAST_BIT);
  end

  // Shift and count on each enabled cycle; hold otherwise so a partial
  // word survives a pause in Shift-DR
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_clr) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_shift_en) begin
      r_shift <= w_next[DATA_WIDTH-1:1];
      r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

  assign o_word = w_next;
  assign o_done = i_shift_en & w_last;

endmodule

// File: rtl/ahb_fifo_write.sv
// JTAG-side writer: deserialises TDI in Shift-DR and pushes words into the async FIFO.
// Latency: winc rises the cycle after the completing TDI bit when the FIFO is not full.
// Backpressure: word held while full; a word completing behind a held word is dropped and flagged.
module ahb_fifo_write
  import ahb_fifo_write_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  TCK,
  input  logic                  TRST,
  input  logic                  tlr_reset,
  input  logic                  dr_shift,
  input  logic                  ahb_fifo_write_select,
  input  logic                  TDI,
  input  logic                  full,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  winc,
  output logic                  overflow
);

  fifo_wr_state_t        r_state;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_overflow;

  logic                  w_shift_en;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_done;
  logic                  w_push;

  // Shift only when our DR is the one selected and the TAP is in Shift-DR
  always_comb begin
    w_shift_en = dr_shift & ahb_fifo_write_select;
  end

  ahb_fifo_write_sipo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sipo (
    .TCK        (TCK),
    .TRST       (TRST),
    .i_clr      (tlr_reset),
    .i_shift_en (w_shift_en),
    .i_tdi      (TDI),
    .o_word     (w_word),
    .o_done     (w_done)
  );

  // Push strobe: only from a loaded holding register and never into a full FIFO
  always_comb begin
    w_push = (r_state == FW_PUSH) & ~full;
  end

  // Holding-register FSM: load on word completion, release on push, drop
  // and flag a new word that arrives while the held one is stalled
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      r_state    <= FW_IDLE;
      r_wdata    <= '0;
      r_overflow <= 1'b0;
    end else if (tlr_reset) begin
      r_state    <= FW_IDLE;
      r_wdata    <= '0;
      r_overflow <= 1'b0;
    end else if (r_state == FW_IDLE) begin
      if (w_done) begin
        r_wdata <= w_word;
        r_state <= FW_PUSH;
      end
    end else begin
      if (!full) begin
        // Held word leaves this cycle; a word completing now takes its place
        if (w_done) begin
          r_wdata <= w_word;
        end else begin
          r_state <= FW_IDLE;
        end
      end else if (w_done) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign wdata    = r_wdata;
  assign winc     = w_push;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_ahb_fifo_write.sv
// Directed bench for ahb_fifo_write with a push scoreboard.
// Expected FIFO words are queued as stimulus completes them; a monitor pops on every winc.
// Inputs change 2 time units after the rising edge; outputs are sampled on the falling edge.
module tb_ahb_fifo_write;

  logic       TCK = 1'b0;
  logic       TRST = 1'b0;
  logic       tlr_reset = 1'b0;
  logic       dr_shift = 1'b0;
  logic       ahb_fifo_write_select = 1'b0;
  logic       TDI = 1'b0;
  logic       full = 1'b0;
  logic [7:0] wdata;
  logic       winc;
  logic       overflow;

  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         winc_cyc[$];

  ahb_fifo_write #(.DATA_WIDTH(8)) dut (
    .TCK                   (TCK),
    .TRST                  (TRST),
    .tlr_reset             (tlr_reset),
    .dr_shift              (dr_shift),
    .ahb_fifo_write_select (ahb_fifo_write_select),
    .TDI                   (TDI),
    .full                  (full),
    .wdata                 (wdata),
    .winc                  (winc),
    .overflow              (overflow)
  );

  always #5 TCK = ~TCK;

  always @(posedge TCK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge TCK);
    #2;
  endtask

  // Shift bits [lo..hi] of w, LSB first, with the DR selected and in Shift-DR
  task automatic shift_bits(input logic [7:0] w, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      dr_shift = 1'b1;
      ahb_fifo_write_select = 1'b1;
      TDI = w[i];
      step();
    end
    dr_shift = 1'b0;
    TDI = 1'b0;
  endtask

  // Monitor: every winc must match the next expected word and never coincide with full
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge TCK);
      if (winc === 1'b1) begin
        winc_cyc.push_back(cyc);
        check("winc_while_full", {31'd0, full}, 32'd0);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_winc: got push of %0h expected no push (cycle %0d)", wdata, cyc);
        end else begin
          e = exp_q.pop_front();
          check("push_wdata", {24'd0, wdata}, {24'd0, e});
        end
      end
    end
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    int n1;

    // 1. Reset with random inputs, then release with dr_shift low
    for (int i = 0; i < 6; i++) begin
      dr_shift = 1'($urandom_range(0, 1));
      ahb_fifo_write_select = 1'($urandom_range(0, 1));
      TDI = 1'($urandom_range(0, 1));
      full = 1'($urandom_range(0, 1));
      tlr_reset = 1'($urandom_range(0, 1));
      step();
    end
    @(negedge TCK);
    check("rst_wdata", {24'd0, wdata}, 32'd0);
    check("rst_winc", {31'd0, winc}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    step();
    dr_shift = 1'b0;
    ahb_fifo_write_select = 1'b1;
    full = 1'b0;
    tlr_reset = 1'b0;
    TDI = 1'b1;
    TRST = 1'b1;
    repeat (4) step();
    @(negedge TCK);
    check("post_rst_wdata", {24'd0, wdata}, 32'd0);
    check("post_rst_winc", {31'd0, winc}, 32'd0);
    check("post_rst_overflow", {31'd0, overflow}, 32'd0);
    step();

    // 2. Single word
    shift_bits(8'hA5, 0, 7);
    exp_q.push_back(8'hA5);
    repeat (3) step();

    // 3. Back-to-back words, pushes exactly 8 cycles apart
    n0 = winc_cyc.size();
    shift_bits(8'h3C, 0, 7);
    exp_q.push_back(8'h3C);
    shift_bits(8'hC3, 0, 7);
    exp_q.push_back(8'hC3);
    repeat (3) step();
    check("b2b_push_count", 32'(winc_cyc.size() - n0), 32'd2);
    if (winc_cyc.size() - n0 == 2)
      check("b2b_spacing", 32'(winc_cyc[n0+1] - winc_cyc[n0]), 32'd8);

    // 4. Backpressure: word held for 5 cycles, then pushed when full drops
    full = 1'b1;
    shift_bits(8'h5A, 0, 7);
    for (int i = 0; i < 5; i++) begin
      @(negedge TCK);
      check("bp_winc_low", {31'd0, winc}, 32'd0);
      check("bp_wdata_held", {24'd0, wdata}, 32'h5A);
      step();
    end
    exp_q.push_back(8'h5A);
    full = 1'b0;
    repeat (3) step();
    @(negedge TCK);
    check("bp_no_overflow", {31'd0, overflow}, 32'd0);
    step();

    // 5. Overflow: second word completes while first is stalled
    full = 1'b1;
    shift_bits(8'h11, 0, 7);
    shift_bits(8'h22, 0, 7);
    @(negedge TCK);
    check("ov_wdata", {24'd0, wdata}, 32'h11);
    check("ov_flag", {31'd0, overflow}, 32'd1);
    step();
    exp_q.push_back(8'h11);
    full = 1'b0;
    repeat (4) step();
    @(negedge TCK);
    check("ov_sticky", {31'd0, overflow}, 32'd1);
    step();

    // 6a. Pause in Shift-DR keeps the partial word
    shift_bits(8'h96, 0, 3);
    repeat (3) step();
    shift_bits(8'h96, 4, 7);
    exp_q.push_back(8'h96);
    repeat (3) step();

    // 6b. Deselect mid-word with garbage TDI behaves as a pause
    shift_bits(8'hE7, 0, 2);
    dr_shift = 1'b1;
    ahb_fifo_write_select = 1'b0;
    TDI = 1'b0;
    repeat (2) step();
    dr_shift = 1'b0;
    shift_bits(8'hE7, 3, 7);
    exp_q.push_back(8'hE7);
    repeat (3) step();

    // 6c. tlr_reset in the pause discards the partial word and clears overflow
    shift_bits(8'h7E, 0, 3);
    tlr_reset = 1'b1;
    step();
    tlr_reset = 1'b0;
    repeat (2) step();
    @(negedge TCK);
    check("tlr_overflow_clr", {31'd0, overflow}, 32'd0);
    step();
    n1 = winc_cyc.size();
    shift_bits(8'hB4, 0, 3);
    @(negedge TCK);
    check("tlr_no_winc", {31'd0, winc}, 32'd0);
    check("tlr_no_push", 32'(winc_cyc.size() - n1), 32'd0);
    step();
    shift_bits(8'hB4, 4, 7);
    exp_q.push_back(8'hB4);
    repeat (3) step();

    // 7. Async reset while a stalled word is held
    full = 1'b1;
    shift_bits(8'h5F, 0, 7);
    step();
    TRST = 1'b0;
    @(negedge TCK);
    check("trst_push_winc", {31'd0, winc}, 32'd0);
    check("trst_push_wdata", {24'd0, wdata}, 32'd0);
    step();
    TRST = 1'b1;
    full = 1'b0;
    repeat (4) step();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
